// File: rtl/rf_writeback_ctrl_if.sv
// Writeback bus between the two producers, the register-file write port,
// and decode's hazard query. The master side is the environment (producers,
// register file, decode). The slave side is rf_writeback_ctrl.
interface rf_writeback_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);

  // ALU result path
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;

  // Memory load path
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;

  // Register-file write port
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_dest;
  logic [DATA_W-1:0] wr_data;

  // Decode hazard query
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              src1_busy;
  logic              src2_busy;

  // Occupancy
  logic [ADDR_W:0]   fifo_count;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output mem_valid, mem_dest, mem_data,
    output wr_stall, src1, src2,
    input  alu_ready, mem_ready,
    input  wr_en, wr_dest, wr_data,
    input  src1_busy, src2_busy, fifo_count
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  mem_valid, mem_dest, mem_data,
    input  wr_stall, src1, src2,
    output alu_ready, mem_ready,
    output wr_en, wr_dest, wr_data,
    output src1_busy, src2_busy, fifo_count
  );

endinterface

// File: rtl/rf_writeback_ctrl.sv
// Write-side controller for the register file. It arbitrates ALU and load
// writebacks into a small in-order FIFO and retires one write per cycle.
// It also flags queued writes that hit decode's source registers.
module rf_writeback_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rf_writeback_ctrl_if.slave      bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FCNT_W = ADDR_W + 1;
  localparam int unsigned STV_W  = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  // FIFO state
  entry_t             fifo_q [DEPTH];
  logic [DEPTH-1:0]   vld_q;
  logic [DEPTH-1:0]   vld_n;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [STV_W-1:0]   starve_q;
  logic [STV_W-1:0]   starve_n;

  // Combinational control
  logic               can_push_c;
  logic               alu_prio_c;
  logic               alu_ready_c;
  logic               mem_ready_c;
  logic               alu_fire_c;
  logic               mem_fire_c;
  logic               push_c;
  logic               pop_c;
  entry_t             push_entry_c;
  entry_t             head_c;
  logic               src1_busy_c;
  logic               src2_busy_c;

  // Admission: no push-through when full, mem wins unless the ALU is starved
  always_comb begin
    can_push_c  = (count_q < CNT_W'(DEPTH));
    alu_prio_c  = (starve_q == STV_W'(STARVE_MAX));
    mem_ready_c = rst_n && can_push_c && (!bus.alu_valid || !alu_prio_c);
    alu_ready_c = rst_n && can_push_c && (!bus.mem_valid || alu_prio_c);
    mem_fire_c  = bus.mem_valid && mem_ready_c;
    alu_fire_c  = bus.alu_valid && alu_ready_c;
    push_c      = mem_fire_c || alu_fire_c;
  end

  // Select the payload of whichever producer transfers this cycle
  always_comb begin
    push_entry_c = '0;
    if (mem_fire_c) begin
      push_entry_c.dest = bus.mem_dest;
      push_entry_c.data = bus.mem_data;
    end else begin
      push_entry_c.dest = bus.alu_dest;
      push_entry_c.data = bus.alu_data;
    end
  end

  // Retire the head whenever something is queued and the port is free
  always_comb begin
    head_c = fifo_q[rd_ptr_q];
    pop_c  = rst_n && (count_q != '0) && !bus.wr_stall;
  end

  // Starvation tracking: count ALU losses while space was available
  always_comb begin
    starve_n = starve_q;
    if (alu_fire_c) begin
      starve_n = '0;
    end else if (bus.alu_valid && can_push_c && !alu_prio_c) begin
      starve_n = starve_q + STV_W'(1);
    end
  end

  // Next-state valid bits. Push and pop never target the same slot,
  // because wr_ptr == rd_ptr only when the FIFO is empty or full.
  always_comb begin
    vld_n = vld_q;
    if (pop_c) begin
      vld_n[rd_ptr_q] = 1'b0;
    end
    if (push_c) begin
      vld_n[wr_ptr_q] = 1'b1;
    end
  end

  // Hazard lookup over every valid entry, including the head now retiring
  always_comb begin
    src1_busy_c = 1'b0;
    src2_busy_c = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld_q[i] && (fifo_q[i].dest == bus.src1)) begin
        src1_busy_c = 1'b1;
      end
      if (vld_q[i] && (fifo_q[i].dest == bus.src2)) begin
        src2_busy_c = 1'b1;
      end
    end
  end

  // Pointer, occupancy, valid-bit and starvation state with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      starve_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q  <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      vld_q    <= vld_n;
      starve_q <= starve_n;
    end
  end

  // Payload storage. Valid bits qualify it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= push_entry_c;
    end
  end

  assign bus.alu_ready  = alu_ready_c;
  assign bus.mem_ready  = mem_ready_c;
  assign bus.wr_en      = pop_c;
  assign bus.wr_dest    = head_c.dest;
  assign bus.wr_data    = head_c.data;
  assign bus.src1_busy  = src1_busy_c;
  assign bus.src2_busy  = src2_busy_c;
  assign bus.fifo_count = FCNT_W'(count_q);

  // Occupancy never exceeds DEPTH and always matches the valid-bit population
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));
  a_count_vld : assert property (@(posedge clk) disable iff (!rst_n)
    $countones(vld_q) == int'(count_q));
  a_single_grant : assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_fire_c && mem_fire_c));

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Scoreboard bench for rf_writeback_ctrl. Accepted requests are queued as
// expected writes. Each retired write is popped and compared in order.
module tb_rf_writeback_ctrl;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  exp_t              sb [$];
  logic [DATA_W-1:0] rf_model [2**ADDR_W];
  int                checks  = 0;
  int                errors  = 0;
  int                retired = 0;

  always #5 clk = ~clk;

  rf_writeback_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_writeback_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Retire checker and acceptance recorder, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.wr_en === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL retire_unexpected: got write dest=%0d data=%h, required no write",
                   bus.wr_dest, bus.wr_data);
        end else begin
          e = sb.pop_front();
          if (bus.wr_dest !== e.dest || bus.wr_data !== e.data) begin
            errors++;
            $display("FAIL retire_order: got dest=%0d data=%h, required dest=%0d data=%h",
                     bus.wr_dest, bus.wr_data, e.dest, e.data);
          end
        end
        rf_model[bus.wr_dest] = bus.wr_data;
        retired++;
      end
      if (bus.mem_valid && bus.mem_ready && bus.alu_valid && bus.alu_ready) begin
        checks++;
        errors++;
        $display("FAIL dual_grant: got both producers accepted, required one");
      end
      if (bus.mem_valid && bus.mem_ready) begin
        sb.push_back('{dest: bus.mem_dest, data: bus.mem_data});
      end else if (bus.alu_valid && bus.alu_ready) begin
        sb.push_back('{dest: bus.alu_dest, data: bus.alu_data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.fifo_count == '0) begin
        ok = 1'b1;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.alu_valid = 1'b1;
    bus.mem_valid = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (bus.alu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_alu_ready: got %b, required 0", bus.alu_ready);
    end
    checks++;
    if (bus.mem_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mem_ready: got %b, required 0", bus.mem_ready);
    end
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_wr_en: got %b, required 0", bus.wr_en);
    end
    checks++;
    if (bus.fifo_count !== 5'd0) begin
      errors++; $display("FAIL reset_count: got %0d, required 0", bus.fifo_count);
    end
    step();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.src1_busy !== 1'b0 || bus.src2_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b%b, required 00", bus.src1_busy, bus.src2_busy);
    end
    step();
  endtask

  task automatic test_single_write();
    bus.src1      = 4'd3;
    bus.alu_dest  = 4'd3;
    bus.alu_data  = 16'h1234;
    bus.alu_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.src1_busy !== 1'b0) begin
      errors++; $display("FAIL single_accept: got ready=%b busy=%b, required ready=1 busy=0",
                         bus.alu_ready, bus.src1_busy);
    end
    step();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_dest !== 4'd3 || bus.wr_data !== 16'h1234) begin
      errors++; $display("FAIL single_write: got en=%b dest=%0d data=%h, required en=1 dest=3 data=1234",
                         bus.wr_en, bus.wr_dest, bus.wr_data);
    end
    checks++;
    if (bus.fifo_count !== 5'd1 || bus.src1_busy !== 1'b1) begin
      errors++; $display("FAIL single_busy: got count=%0d busy=%b, required count=1 busy=1",
                         bus.fifo_count, bus.src1_busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 5'd0 || bus.src1_busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL single_after: got count=%0d busy=%b en=%b, required 0 0 0",
                         bus.fifo_count, bus.src1_busy, bus.wr_en);
    end
    step();
  endtask

  task automatic test_arbitration();
    int unsigned starve = 0;
    bit exp_alu;
    bit ok;
    bus.alu_valid = 1'b1;
    bus.mem_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.mem_dest = ADDR_W'(i);
      bus.mem_data = DATA_W'(32'h8000 + i);
      bus.alu_dest = ADDR_W'(i + 8);
      bus.alu_data = DATA_W'(32'h4000 + i);
      exp_alu = (starve == STARVE_MAX);
      @(negedge clk);
      checks++;
      if (bus.mem_ready !== !exp_alu || bus.alu_ready !== exp_alu) begin
        errors++; $display("FAIL grant_seq[%0d]: got mem=%b alu=%b, required mem=%b alu=%b",
                           i, bus.mem_ready, bus.alu_ready, !exp_alu, exp_alu);
      end
      step();
      if (exp_alu) starve = 0;
      else if (starve < STARVE_MAX) starve++;
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL arb_drain: got nonzero fifo_count at timeout, required 0");
    end
  endtask

  task automatic test_stall_full();
    int r0 = retired;
    bit ok;
    bus.wr_stall  = 1'b1;
    bus.alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.alu_dest = ADDR_W'(i + 1);
      bus.alu_data = DATA_W'(32'hC000 + i);
      @(negedge clk);
      checks++;
      if (bus.alu_ready !== 1'b1) begin
        errors++; $display("FAIL fill_accept[%0d]: got ready=%b, required 1", i, bus.alu_ready);
      end
      step();
    end
    bus.alu_dest = 4'd5;
    bus.alu_data = 16'hC004;
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 5'd4 || bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL full: got count=%0d alu_rdy=%b mem_rdy=%b en=%b, required 4 0 0 0",
                         bus.fifo_count, bus.alu_ready, bus.mem_ready, bus.wr_en);
    end
    step();
    bus.wr_stall = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.alu_ready !== 1'b0) begin
      errors++; $display("FAIL no_push_through: got en=%b ready=%b, required en=1 ready=0",
                         bus.wr_en, bus.alu_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.fifo_count !== 5'd3) begin
      errors++; $display("FAIL fifth_accept: got ready=%b count=%0d, required ready=1 count=3",
                         bus.alu_ready, bus.fifo_count);
    end
    step();
    bus.alu_valid = 1'b0;
    drain(ok);
    checks++;
    if (!ok || (retired - r0) != 5) begin
      errors++; $display("FAIL stall_drain: got drained=%b retired=%0d, required 1 and 5",
                         ok, retired - r0);
    end
  endtask

  task automatic test_same_dest();
    bus.wr_stall  = 1'b1;
    bus.src2      = 4'd7;
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 4'd7;
    bus.alu_data  = 16'hAAAA;
    step();
    bus.alu_data  = 16'h5555;
    step();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 5'd2 || bus.src2_busy !== 1'b1) begin
      errors++; $display("FAIL same_queued: got count=%0d busy=%b, required 2 1",
                         bus.fifo_count, bus.src2_busy);
    end
    step();
    bus.wr_stall = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_data !== 16'hAAAA || bus.src2_busy !== 1'b1) begin
      errors++; $display("FAIL same_first: got data=%h busy=%b, required aaaa 1",
                         bus.wr_data, bus.src2_busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.wr_data !== 16'h5555 || bus.src2_busy !== 1'b1) begin
      errors++; $display("FAIL same_second: got data=%h busy=%b, required 5555 1",
                         bus.wr_data, bus.src2_busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.src2_busy !== 1'b0 || rf_model[7] !== 16'h5555) begin
      errors++; $display("FAIL same_final: got busy=%b r7=%h, required 0 5555",
                         bus.src2_busy, rf_model[7]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.wr_stall  = 1'b1;
    bus.alu_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.alu_dest = ADDR_W'(i);
      bus.alu_data = DATA_W'(32'hD000 + i);
      step();
    end
    bus.alu_valid = 1'b0;
    bus.src1 = 4'd1;
    bus.src2 = 4'd2;
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 5'd3 || bus.src1_busy !== 1'b1) begin
      errors++; $display("FAIL mid_queued: got count=%0d busy=%b, required 3 1",
                         bus.fifo_count, bus.src1_busy);
    end
    step();
    rst_n = 1'b0;
    sb.delete();
    bus.wr_stall = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL mid_rst_wr_en: got %b, required 0", bus.wr_en);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 5'd0 || bus.wr_en !== 1'b0 || bus.src1_busy !== 1'b0 || bus.src2_busy !== 1'b0) begin
      errors++; $display("FAIL mid_cleared: got count=%0d en=%b busy=%b%b, required 0 0 00",
                         bus.fifo_count, bus.wr_en, bus.src1_busy, bus.src2_busy);
    end
    step();
    rst_n = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 4'd5;
    bus.alu_data  = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.wr_en !== 1'b0 || bus.fifo_count !== 5'd0) begin
      errors++; $display("FAIL mid_resume: got ready=%b en=%b count=%0d, required 1 0 0",
                         bus.alu_ready, bus.wr_en, bus.fifo_count);
    end
    step();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_dest !== 4'd5 || bus.wr_data !== 16'hBEEF) begin
      errors++; $display("FAIL mid_write: got en=%b dest=%0d data=%h, required 1 5 beef",
                         bus.wr_en, bus.wr_dest, bus.wr_data);
    end
    step();
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mid_drain: got nonzero fifo_count at timeout, required 0");
    end
  endtask

  task automatic test_back_to_back_wrap();
    int r0 = retired;
    bit ok;
    bus.alu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.alu_dest = ADDR_W'(i);
      bus.alu_data = DATA_W'(32'hE000 + i);
      @(negedge clk);
      checks++;
      if (bus.alu_ready !== 1'b1) begin
        errors++; $display("FAIL wrap_accept[%0d]: got ready=%b, required 1", i, bus.alu_ready);
      end
      step();
    end
    bus.alu_valid = 1'b0;
    drain(ok);
    checks++;
    if (!ok || (retired - r0) != 10 || rf_model[9] !== 16'hE009) begin
      errors++; $display("FAIL wrap_total: got drained=%b retired=%0d r9=%h, required 1 10 e009",
                         ok, retired - r0, rf_model[9]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_dest  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_dest  = '0;
    bus.mem_data  = '0;
    bus.wr_stall  = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    #1;
    test_reset();
    test_single_write();
    test_arbitration();
    test_stall_full();
    test_same_dest();
    test_reset_mid();
    test_back_to_back_wrap();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
